hex_page_sched: RTL and testbench

HEX_PAGE_SCHED -- requirements
Module: hex_page_sched

---
 rtl/hex_page_sched.sv | 160 ++++++++++++++++
 tb/tb_hex_page_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_page_sched.sv
// Register/data-bus page viewer for eight 7-segment digits.
// Debounced page button, manual/auto-scroll/hold modes, registered digit outputs.
module hex_page_sched #(
  parameter int DB_CYCLES = 500000,
  parameter int TICK_DIV  = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [9:0] R0,
  input  logic [9:0] R1,
  input  logic [9:0] R2,
  input  logic [9:0] R3,
  input  logic [9:0] R4,
  input  logic [9:0] R5,
  input  logic [9:0] R6,
  input  logic [9:0] R7,
  input  logic [9:0] DIN,
  input  logic       PageBtn,
  input  logic       AutoEn,
  input  logic       Hold,
  output logic [3:0] Dig0,
  output logic [3:0] Dig1,
  output logic [3:0] Dig2,
  output logic [3:0] Dig3,
  output logic [3:0] Dig4,
  output logic [3:0] Dig5,
  output logic [3:0] Dig6,
  output logic [3:0] Dig7,
  output logic [7:0] Blank,
  output logic [2:0] Page
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int TKW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TKW-1:0] TK_LAST = TKW'(TICK_DIV - 1);

  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} state_t;

  logic [9:0] w_regs [8];
  assign w_regs[0] = R0;
  assign w_regs[1] = R1;
  assign w_regs[2] = R2;
  assign w_regs[3] = R3;
  assign w_regs[4] = R4;
  assign w_regs[5] = R5;
  assign w_regs[6] = R6;
  assign w_regs[7] = R7;

  logic           r_sync1, r_sync2, r_db_level, r_press;
  logic [DBW-1:0] r_db_cnt;

  // r_db_level resets to "pressed" so a button held through reset must be
  // released for DB_CYCLES before a new press can be accepted.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b0;
      r_db_cnt   <= '0;
      r_press    <= 1'b0;
    end else begin
      r_sync1 <= PageBtn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_cnt   <= '0;
        r_db_level <= r_sync2;
        r_press    <= ~r_sync2;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  state_t         r_state, w_state_next;
  logic [2:0]     r_page, w_page_inc;
  logic [TKW-1:0] r_tick;
  logic [3:0]     r_dig [8];
  logic [3:0]     w_dig_next [8];
  logic [7:0]     r_blank, w_blank_next;
  logic [9:0]     w_a, w_b;
  logic           w_enter_auto, w_tick_last;

  always_comb begin
    if (Hold)        w_state_next = HOLD;
    else if (AutoEn) w_state_next = AUTO;
    else             w_state_next = MANUAL;
  end

  assign w_enter_auto = (w_state_next == AUTO) && (r_state != AUTO);
  assign w_tick_last  = (r_tick == TK_LAST);
  assign w_page_inc   = (r_page >= 3'd4) ? 3'd0 : r_page + 3'd1;
  assign w_a          = w_regs[{r_page[1:0], 1'b0}];
  assign w_b          = w_regs[{r_page[1:0], 1'b1}];

  always_comb begin
    w_dig_next[3] = {1'b0, r_page};
    w_dig_next[7] = DIN[9:6];
    if (r_page < 3'd4) begin
      w_dig_next[0] = w_a[3:0];
      w_dig_next[1] = w_a[7:4];
      w_dig_next[2] = {2'b00, w_a[9:8]};
      w_dig_next[4] = w_b[3:0];
      w_dig_next[5] = w_b[7:4];
      w_dig_next[6] = {2'b00, w_b[9:8]};
      w_blank_next  = 8'h00;
    end else begin
      w_dig_next[0] = DIN[3:0];
      w_dig_next[1] = DIN[7:4];
      w_dig_next[2] = {2'b00, DIN[9:8]};
      w_dig_next[4] = 4'h0;
      w_dig_next[5] = 4'h0;
      w_dig_next[6] = 4'h0;
      w_blank_next  = 8'h70;
    end
  end

  // Mode behaviour follows the state being entered, so Hold/AutoEn act on the
  // same edge that samples them.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= MANUAL;
      r_page  <= 3'd0;
      r_tick  <= '0;
      r_blank <= 8'h00;
      for (int i = 0; i < 8; i++) r_dig[i] <= 4'h0;
    end else begin
      r_state <= w_state_next;
      case (w_state_next)
        MANUAL: begin
          r_tick <= '0;
          if (r_press) r_page <= w_page_inc;
        end
        AUTO: begin
          if (w_enter_auto || r_press || w_tick_last) r_tick <= '0;
          else                                        r_tick <= r_tick + 1'b1;
          if (r_press || (w_tick_last && !w_enter_auto)) r_page <= w_page_inc;
        end
        default: ;
      endcase
      if (w_state_next != HOLD) begin
        r_blank <= w_blank_next;
        for (int i = 0; i < 8; i++) r_dig[i] <= w_dig_next[i];
      end
    end
  end

  assign Dig0  = r_dig[0];
  assign Dig1  = r_dig[1];
  assign Dig2  = r_dig[2];
  assign Dig3  = r_dig[3];
  assign Dig4  = r_dig[4];
  assign Dig5  = r_dig[5];
  assign Dig6  = r_dig[6];
  assign Dig7  = r_dig[7];
  assign Blank = r_blank;
  assign Page  = r_page;
endmodule

// File: tb/tb_hex_page_sched.sv
// Self-checking bench for hex_page_sched with DB_CYCLES=4, TICK_DIV=16.
// Display table vectors, hand sequences for debounce/hold/auto/reset, random inputs.
module tb_hex_page_sched;
  localparam int DB = 4;
  localparam int TK = 16;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] regs [8];
  logic [9:0] din;
  logic       btn, auto_en, hold;
  logic [3:0] dig [8];
  logic [7:0] blank;
  logic [2:0] page;

  int n_checks = 0;
  int n_fail   = 0;
  int m_page   = 0;

  typedef struct {
    int          pg;
    logic [9:0]  ra;
    logic [9:0]  rb;
    logic [9:0]  dn;
    logic [31:0] exp_dig;
    logic [7:0]  exp_bl;
  } vec_t;
  vec_t tbl [8];

  hex_page_sched #(.DB_CYCLES(DB), .TICK_DIV(TK)) dut (
    .Clock(Clock), .Reset(Reset),
    .R0(regs[0]), .R1(regs[1]), .R2(regs[2]), .R3(regs[3]),
    .R4(regs[4]), .R5(regs[5]), .R6(regs[6]), .R7(regs[7]),
    .DIN(din), .PageBtn(btn), .AutoEn(auto_en), .Hold(hold),
    .Dig0(dig[0]), .Dig1(dig[1]), .Dig2(dig[2]), .Dig3(dig[3]),
    .Dig4(dig[4]), .Dig5(dig[5]), .Dig6(dig[6]), .Dig7(dig[7]),
    .Blank(blank), .Page(page)
  );

  always #5 Clock = ~Clock;

  // Expected {Blank, Dig7..Dig0} for page p with shown registers a/b and data bus d.
  function automatic logic [39:0] disp(input int p, input logic [9:0] a,
                                       input logic [9:0] b, input logic [9:0] d);
    logic [3:0] x [8];
    logic [7:0] bl;
    x[3] = 4'(p);
    x[7] = d[9:6];
    if (p < 4) begin
      x[0] = a[3:0]; x[1] = a[7:4]; x[2] = {2'b00, a[9:8]};
      x[4] = b[3:0]; x[5] = b[7:4]; x[6] = {2'b00, b[9:8]};
      bl = 8'h00;
    end else begin
      x[0] = d[3:0]; x[1] = d[7:4]; x[2] = {2'b00, d[9:8]};
      x[4] = 4'h0;   x[5] = 4'h0;   x[6] = 4'h0;
      bl = 8'h70;
    end
    return {bl, x[7], x[6], x[5], x[4], x[3], x[2], x[1], x[0]};
  endfunction

  function automatic logic [39:0] model_disp(input int p);
    return disp(p, regs[(2*p) & 7], regs[(2*p+1) & 7], din);
  endfunction

  function automatic logic [39:0] outs();
    return {blank, dig[7], dig[6], dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < 8; k++) regs[k] = 10'($urandom);
    din = 10'($urandom);
  endtask

  task automatic press();
    btn = 1'b0;
    repeat (8) @(negedge Clock);
    btn = 1'b1;
    repeat (8) @(negedge Clock);
    m_page = (m_page + 1) % 5;
    check("press page", 40'(page), 40'(m_page));
  endtask

  initial begin
    logic [39:0] exp, m_out;
    int          last_ref, pre;

    tbl[0] = '{0, 10'h3A5, 10'h012, 10'h2C0, 32'hB01203A5, 8'h00};
    tbl[1] = '{0, 10'h3FF, 10'h3FF, 10'h3FF, 32'hF3FF03FF, 8'h00};
    tbl[2] = '{0, 10'h000, 10'h000, 10'h000, 32'h00000000, 8'h00};
    tbl[3] = '{0, 10'h1C3, 10'h25A, 10'h155, 32'h525A01C3, 8'h00};
    tbl[4] = '{0, 10'h200, 10'h100, 10'h040, 32'h11000200, 8'h00};
    tbl[5] = '{2, 10'h0AB, 10'h31E, 10'h0C0, 32'h331E20AB, 8'h00};
    tbl[6] = '{4, 10'h155, 10'h2AA, 10'h2C0, 32'hB00042C0, 8'h70};
    tbl[7] = '{4, 10'h155, 10'h2AA, 10'h3FF, 32'hF00043FF, 8'h70};

    for (int k = 0; k < 8; k++) regs[k] = 10'h3FF;
    din = 10'h3FF; btn = 1'b1; auto_en = 1'b0; hold = 1'b0;

    // Reset state
    repeat (2) @(negedge Clock);
    check("reset outs", outs(), 40'h0);
    check("reset page", 40'(page), 40'h0);
    Reset = 1'b0;
    repeat (10) @(negedge Clock);

    // Display table, pressing forward to each row's page
    for (int i = 0; i < 8; i++) begin
      while (m_page != tbl[i].pg) press();
      randomize_inputs();
      if (tbl[i].pg < 4) begin
        regs[2*tbl[i].pg]   = tbl[i].ra;
        regs[2*tbl[i].pg+1] = tbl[i].rb;
      end
      din = tbl[i].dn;
      @(negedge Clock);
      check($sformatf("table row %0d outs", i), outs(), {tbl[i].exp_bl, tbl[i].exp_dig});
      check($sformatf("table row %0d page", i), 40'(page), 40'(tbl[i].pg));
    end
    press();  // 4 -> 0 wrap

    // Short glitch must not register
    btn = 1'b0;
    repeat (3) @(negedge Clock);
    btn = 1'b1;
    repeat (10) @(negedge Clock);
    check("glitch page", 40'(page), 40'(m_page));

    // Long press: exactly one advance, at edge 7
    btn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge Clock);
      check($sformatf("press edge %0d", k), 40'(page), (k >= 7) ? 40'd1 : 40'd0);
    end
    btn = 1'b1;
    repeat (8) @(negedge Clock);
    m_page = 1;
    check("after long press", 40'(page), 40'(m_page));

    // Hold freezes everything and swallows a press
    randomize_inputs();
    @(negedge Clock);
    hold = 1'b1;
    m_out = model_disp(m_page);
    @(negedge Clock);
    regs[0] = ~regs[0];
    regs[2] = ~regs[2];
    regs[3] = regs[3] ^ 10'h155;
    for (int k = 0; k < 16; k++) begin
      btn = (k < 8) ? 1'b0 : 1'b1;
      @(negedge Clock);
      if (k % 4 == 3) begin
        check($sformatf("hold outs %0d", k), outs(), m_out);
        check($sformatf("hold page %0d", k), 40'(page), 40'(m_page));
      end
    end
    hold = 1'b0;
    exp = model_disp(m_page);
    @(negedge Clock);
    check("unhold outs", outs(), exp);
    repeat (3) @(negedge Clock);
    check("unhold page", 40'(page), 40'(m_page));

    // Auto-scroll with a coincident press (edge 33) and a mid-period press (edge 61)
    auto_en  = 1'b1;
    last_ref = 1;
    for (int e = 1; e <= 80; e++) begin
      btn = ((e >= 27 && e <= 34) || (e >= 55 && e <= 62)) ? 1'b0 : 1'b1;
      randomize_inputs();
      pre = m_page;
      exp = model_disp(pre);
      if (e == 33 || e == 61 || (e - last_ref == TK)) begin
        m_page   = (m_page + 1) % 5;
        last_ref = e;
      end
      @(negedge Clock);
      m_out = exp;
      if (e % 4 == 1 || e == 33 || e == 61 || e == 65 || e == 77) begin
        check($sformatf("auto e%0d page", e), 40'(page), 40'(m_page));
        check($sformatf("auto e%0d outs", e), outs(), exp);
      end
    end
    auto_en = 1'b0;

    // Random inputs with random Hold in MANUAL
    for (int i = 0; i < 40; i++) begin
      hold = ($urandom_range(0, 2) == 0);
      randomize_inputs();
      if (!hold) m_out = model_disp(m_page);
      @(negedge Clock);
      check($sformatf("rand %0d outs", i), outs(), m_out);
      check($sformatf("rand %0d page", i), 40'(page), 40'(m_page));
    end
    hold = 1'b0;
    repeat (2) @(negedge Clock);

    // Reset mid-press on page 3 with the button held through release
    while (m_page != 3) press();
    btn = 1'b0;
    repeat (4) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("async reset outs", outs(), 40'h0);
    check("async reset page", 40'(page), 40'h0);
    repeat (3) @(negedge Clock);
    Reset  = 1'b0;
    m_page = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clock);
      if (k % 5 == 4) check($sformatf("held after reset %0d", k), 40'(page), 40'(m_page));
    end
    btn = 1'b1;
    repeat (8) @(negedge Clock);
    press();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
